// File: rtl/ctrl_unit_add_if.sv
// rtl/ctrl_unit_add_if.sv - control bundle between ctrl_unit_add and the add-path datapath
// master = control FSM (consumes IR fields, drives enables/selects); slave = datapath.
interface ctrl_unit_add_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       pc_w;
   logic       mem_w;
   logic       ir_w;
   logic       m_wreg;
   logic       rb_w;
   logic       ab_w;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] ula_op;
   logic       rst_out;
   logic       illegal_op;

   modport master (
      input  opcode, funct,
      output pc_w, mem_w, ir_w, m_wreg, rb_w, ab_w,
             alu_src_a, alu_src_b, ula_op, rst_out, illegal_op
   );

   modport slave (
      output opcode, funct,
      input  pc_w, mem_w, ir_w, m_wreg, rb_w, ab_w,
             alu_src_a, alu_src_b, ula_op, rst_out, illegal_op
   );
endinterface

// File: rtl/ctrl_unit_add.sv
// rtl/ctrl_unit_add.sv - multicycle FETCH/DECODE/EXEC/WB control FSM for the ADD/ADDI datapath
// Optional ILLEGAL_OP_TRAP_EN: unsupported opcodes park the FSM in ST_TRAP until reset.
module ctrl_unit_add #(
   parameter int unsigned MEM_WAIT_CYCLES = 2
) (
   input logic             clock,
   input logic             reset,
   ctrl_unit_add_if.master bus
);

   localparam logic [2:0] FETCH_LAST = 3'(MEM_WAIT_CYCLES);
   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] OP_ADDI    = 6'h08;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [2:0] ULA_PASS_A = 3'b000;
   localparam logic [2:0] ULA_ADD    = 3'b001;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_ADD,
      ST_WB_ADD,
      ST_EXEC_ADDI,
      ST_WB_ADDI
`ifdef ILLEGAL_OP_TRAP_EN
      , ST_TRAP
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   logic       is_add, is_addi;
   logic       pc_w, mem_w, ir_w, m_wreg, rb_w, ab_w, alu_src_a, rst_out, illegal_op;
   logic [1:0] alu_src_b;
   logic [2:0] ula_op;

   assign is_add  = (bus.opcode == OP_RTYPE) && (bus.funct == FN_ADD);
   assign is_addi = (bus.opcode == OP_ADDI);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_RESET;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The wait counter defaults to zero so every entry into ST_FETCH starts a fresh count.
   always_comb begin
      state_d = state_q;
      cnt_d   = 3'd0;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            if (cnt_q == FETCH_LAST) begin
               state_d = ST_DECODE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_DECODE: begin
            if (is_add) begin
               state_d = ST_EXEC_ADD;
            end else if (is_addi) begin
               state_d = ST_EXEC_ADDI;
            end else begin
`ifdef ILLEGAL_OP_TRAP_EN
               state_d = ST_TRAP;
`else
               state_d = ST_FETCH;
`endif
            end
         end
         ST_EXEC_ADD:  state_d = ST_WB_ADD;
         ST_WB_ADD:    state_d = ST_FETCH;
         ST_EXEC_ADDI: state_d = ST_WB_ADDI;
         ST_WB_ADDI:   state_d = ST_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         ST_TRAP:      state_d = ST_TRAP;
`endif
         default:      state_d = ST_RESET;
      endcase
   end

   // Moore decode: every output is a pure function of the registered state and counter.
   always_comb begin
      pc_w       = 1'b0;
      mem_w      = 1'b0;
      ir_w       = 1'b0;
      m_wreg     = 1'b0;
      rb_w       = 1'b0;
      ab_w       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      ula_op     = ULA_PASS_A;
      rst_out    = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         ST_RESET: rst_out = 1'b1;
         ST_FETCH: begin
            alu_src_a = 1'b0;
            alu_src_b = SRCB_FOUR;
            ula_op    = ULA_ADD;
            if (cnt_q == FETCH_LAST) begin
               ir_w = 1'b1;
               pc_w = 1'b1;
            end
         end
         ST_DECODE: ab_w = 1'b1;
         ST_EXEC_ADD: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            ula_op    = ULA_ADD;
         end
         ST_WB_ADD: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_B;
            ula_op    = ULA_ADD;
            rb_w      = 1'b1;
            m_wreg    = 1'b1;
         end
         ST_EXEC_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            ula_op    = ULA_ADD;
         end
         ST_WB_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            ula_op    = ULA_ADD;
            rb_w      = 1'b1;
            m_wreg    = 1'b0;
         end
`ifdef ILLEGAL_OP_TRAP_EN
         ST_TRAP: illegal_op = 1'b1;
`endif
         default: rst_out = 1'b1;
      endcase
   end

   assign bus.pc_w       = pc_w;
   assign bus.mem_w      = mem_w;
   assign bus.ir_w       = ir_w;
   assign bus.m_wreg     = m_wreg;
   assign bus.rb_w       = rb_w;
   assign bus.ab_w       = ab_w;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.ula_op     = ula_op;
   assign bus.rst_out    = rst_out;
   assign bus.illegal_op = illegal_op;

   // Register-file and PC enables must stay single-cycle pulses.
   a_pc_pulse:  assert property (@(posedge clock) disable iff (!reset) pc_w |=> !pc_w);
   a_ir_pulse:  assert property (@(posedge clock) disable iff (!reset) ir_w |=> !ir_w);
   a_ab_pulse:  assert property (@(posedge clock) disable iff (!reset) ab_w |=> !ab_w);
   a_rb_pulse:  assert property (@(posedge clock) disable iff (!reset) rb_w |=> !rb_w);
   a_no_store:  assert property (@(posedge clock) !mem_w);

endmodule

// File: tb/tb_ctrl_unit_add.sv
// tb/tb_ctrl_unit_add.sv - bench for ctrl_unit_add (MEM_WAIT_CYCLES=2 and =0 instances)
module tb_ctrl_unit_add;

   typedef struct {
      bit         chk;
      bit         rst_n;
      logic [5:0] op;
      logic [5:0] fn;
      logic [13:0] exp;
   } row_t;

   logic clock;
   logic rst_a, rst_b;
   ctrl_unit_add_if if_a();
   ctrl_unit_add_if if_b();

   ctrl_unit_add #(.MEM_WAIT_CYCLES(2)) u_dut_a (.clock(clock), .reset(rst_a), .bus(if_a));
   ctrl_unit_add #(.MEM_WAIT_CYCLES(0)) u_dut_b (.clock(clock), .reset(rst_b), .bus(if_b));

   always #5 clock = ~clock;

   row_t qa[$];
   row_t qb[$];
   int   ir_a[$], rb_a[$], ir_b[$], rb_b[$];
   int   ill_a;
   int   checks;
   int   errors;
   logic [13:0] e_rst, e_trap;

   // Packed as {pc_w, mem_w, ir_w, m_wreg, rb_w, ab_w, alu_src_a, alu_src_b, ula_op, rst_out, illegal_op}
   function automatic logic [13:0] mk(input bit pc, input bit ir, input bit wreg, input bit rb,
                                      input bit ab, input bit asa, input logic [1:0] asb,
                                      input logic [2:0] uop, input bit rsto, input bit ill);
      return {pc, 1'b0, ir, wreg, rb, ab, asa, asb, uop, rsto, ill};
   endfunction

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic add_row(input int d, input bit c, input bit rn, input logic [5:0] op,
                          input logic [5:0] fn, input logic [13:0] e);
      row_t r;
      r.chk = c; r.rst_n = rn; r.op = op; r.fn = fn; r.exp = e;
      if (d == 0) qa.push_back(r);
      else        qb.push_back(r);
   endtask

   // Reset asserted at the end of the current last row, held n cycles in total, then released.
   task automatic do_reset(input int d, input int n);
      if (d == 0) begin
         if (qa.size() == 0) add_row(0, 1'b0, 1'b0, 6'h00, 6'h00, 14'h0);
         else qa[qa.size()-1].rst_n = 1'b0;
      end else begin
         if (qb.size() == 0) add_row(1, 1'b0, 1'b0, 6'h00, 6'h00, 14'h0);
         else qb[qb.size()-1].rst_n = 1'b0;
      end
      for (int i = 1; i < n; i++) add_row(d, 1'b1, 1'b0, 6'h00, 6'h00, e_rst);
      add_row(d, 1'b1, 1'b1, 6'h00, 6'h00, e_rst);
   endtask

   // Expands one instruction into its cycle-by-cycle control pattern; cut>0 keeps only the first cut cycles.
   task automatic instr(input int d, input logic [5:0] op, input logic [5:0] fn, input int cut);
      logic [13:0] ex[$];
      int mw;
      int n;
      mw = (d == 0) ? 2 : 0;
      for (int i = 0; i <= mw; i++)
         ex.push_back(mk(i == mw, i == mw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, 1'b0, 1'b0));
      ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0));
      if (op == 6'h00 && fn == 6'h20) begin
         ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0));
         ex.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0));
      end else if (op == 6'h08) begin
         ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 1'b0, 1'b0));
         ex.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 3'b001, 1'b0, 1'b0));
      end
      n = (cut > 0 && cut < ex.size()) ? cut : ex.size();
      for (int i = 0; i < n; i++) add_row(d, 1'b1, 1'b1, op, fn, ex[i]);
   endtask

   task automatic trap_hold(input int d, input int n);
      for (int i = 0; i < n; i++) add_row(d, 1'b1, 1'b1, 6'h23, 6'h00, e_trap);
   endtask

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, expv);
      end
   endtask

   initial begin
      logic [13:0] act;
      int n;
      int cnt;
      clock = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      if_a.opcode = 6'h00; if_a.funct = 6'h00;
      if_b.opcode = 6'h00; if_b.funct = 6'h00;
      checks = 0;
      errors = 0;
      ill_a  = -1;
      e_rst  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0);
      e_trap = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);

      // Instance A (MEM_WAIT_CYCLES=2)
      do_reset(0, 3);
      instr(0, 6'h00, 6'h20, 0);
      instr(0, 6'h00, 6'h20, 0);
      instr(0, 6'h08, 6'h15, 0);
      instr(0, 6'h08, 6'h00, 0);
`ifdef ILLEGAL_OP_TRAP_EN
      instr(0, 6'h23, 6'h00, 0);
      trap_hold(0, 20);
`else
      instr(0, 6'h23, 6'h00, 0);
      instr(0, 6'h00, 6'h20, 0);
      instr(0, 6'h00, 6'h22, 0);
      instr(0, 6'h08, 6'h3f, 0);
`endif
      do_reset(0, 2);
      instr(0, 6'h00, 6'h20, 5);
      do_reset(0, 2);
      instr(0, 6'h08, 6'h00, 2);
      do_reset(0, 1);
      instr(0, 6'h00, 6'h20, 0);
      instr(0, 6'h08, 6'h01, 0);

      // Instance B (MEM_WAIT_CYCLES=0)
      do_reset(1, 1);
      instr(1, 6'h00, 6'h20, 0);
      instr(1, 6'h00, 6'h20, 0);
      instr(1, 6'h08, 6'h00, 0);
      instr(1, 6'h00, 6'h20, 3);
      do_reset(1, 1);
      instr(1, 6'h00, 6'h20, 0);

      n = (qa.size() > qb.size()) ? qa.size() : qb.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         if (k < qa.size()) begin
            act = {if_a.pc_w, if_a.mem_w, if_a.ir_w, if_a.m_wreg, if_a.rb_w, if_a.ab_w,
                   if_a.alu_src_a, if_a.alu_src_b, if_a.ula_op, if_a.rst_out, if_a.illegal_op};
            if (qa[k].chk) begin
               checks++;
               if (act !== qa[k].exp) begin
                  errors++;
                  $display("FAIL dut_a row %0d got %h want %h", k, act, qa[k].exp);
               end
               if (if_a.ir_w === 1'b1) ir_a.push_back(k);
               if (if_a.rb_w === 1'b1) rb_a.push_back(k);
               if (if_a.illegal_op === 1'b1 && ill_a < 0) ill_a = k;
            end
            rst_a = qa[k].rst_n;
            if_a.opcode = qa[k].op;
            if_a.funct  = qa[k].fn;
         end else begin
            rst_a = 1'b0;
         end
         if (k < qb.size()) begin
            act = {if_b.pc_w, if_b.mem_w, if_b.ir_w, if_b.m_wreg, if_b.rb_w, if_b.ab_w,
                   if_b.alu_src_a, if_b.alu_src_b, if_b.ula_op, if_b.rst_out, if_b.illegal_op};
            if (qb[k].chk) begin
               checks++;
               if (act !== qb[k].exp) begin
                  errors++;
                  $display("FAIL dut_b row %0d got %h want %h", k, act, qb[k].exp);
               end
               if (if_b.ir_w === 1'b1) ir_b.push_back(k);
               if (if_b.rb_w === 1'b1) rb_b.push_back(k);
            end
            rst_b = qb[k].rst_n;
            if_b.opcode = qb[k].op;
            if_b.funct  = qb[k].fn;
         end else begin
            rst_b = 1'b0;
         end
      end

      // Hand-derived pulse positions (row = cycle index from the start of the run).
      chk("a_first_ir_w", at(ir_a, 0), 6);
      chk("a_second_ir_w", at(ir_a, 1), 12);
      chk("a_add_rb_w", at(rb_a, 0), 9);
      chk("a_add2_rb_w", at(rb_a, 1), 15);
      chk("a_addi_rb_w", at(rb_a, 2), 21);
      chk("a_addi2_rb_w", at(rb_a, 3), 27);
      cnt = 0;
      foreach (rb_a[i]) if (rb_a[i] >= 16 && rb_a[i] <= 27) cnt++;
      chk("a_addi_pair_rb_count", cnt, 2);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("a_trap_first_row", ill_a, 32);
`else
      chk("a_illegal_ir_w", at(ir_a, 4), 30);
      chk("a_after_illegal_ir_w", at(ir_a, 5), 34);
      chk("a_after_illegal_rb_w", at(rb_a, 4), 37);
      chk("a_illegal_op_never", ill_a, -1);
`endif
      chk("b_first_ir_w", at(ir_b, 0), 2);
      chk("b_second_ir_w", at(ir_b, 1), 6);
      chk("b_third_ir_w", at(ir_b, 2), 10);
      chk("b_add_rb_w", at(rb_b, 0), 5);
      chk("b_addi_rb_w", at(rb_b, 2), 13);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
